data_mem_responder: RTL and testbench

- Memory-side responder for the core's data-memory request interface (wr/rd strobe, 9-bit byte address, 32-bit write data, read data).
- Holds a 512-byte little-endian data RAM and services one load or store at a time.
- Models a configurable number of wait states. Returns read data, or a store acknowledge, through a one-cycle response pulse.
- Handles byte, halfword and word accesses with the RV32I sign and zero extension rules.

---
 rtl/data_mem_responder_if.sv | 25 ++
 rtl/data_mem_responder.sv | 133 +++++++++++++
 tb/tb_data_mem_responder.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Data-memory request/response bus between the core (master) and the RAM responder (slave).
interface data_mem_responder_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 9
) ();
  logic              req_rd;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_funct3;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_rd, req_wr, req_addr, req_funct3, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_rd, req_wr, req_addr, req_funct3, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Byte-addressed little-endian data RAM answering one load/store at a time after LATENCY
// wait states, with RV32I size/sign handling and error responses for illegal requests.
module data_mem_responder #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned LATENCY = 2
) (
  input logic                 clk,
  input logic                 reset,
  data_mem_responder_if.slave mem_if
);

  localparam int unsigned Depth   = 2 ** ADDR_W;
  localparam logic [3:0]  CntLoad = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        funct3_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rd_q, wr_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;
  logic [7:0]        mem_q [Depth];

  logic              accept, enter_resp, req_err, misaligned, bad_funct3;
  logic              op_rd, op_wr;
  logic [ADDR_W-1:0] op_addr, a1, a2, a3;
  logic [2:0]        op_f3;
  logic [DATA_W-1:0] op_wdata;
  logic [7:0]        b0, b1, b2, b3;
  logic [31:0]       load_word;

  // Decode the operation being completed; with zero wait states it completes on the accept
  // edge itself, so the live request is used while still idle.
  always_comb begin
    accept     = (state_q == StIdle) && (mem_if.req_rd || mem_if.req_wr);
    enter_resp = ((state_q == StWait) && (cnt_q == 4'd0)) || (accept && (LATENCY == 0));
    if (state_q == StIdle) begin
      op_rd    = mem_if.req_rd;
      op_wr    = mem_if.req_wr;
      op_addr  = mem_if.req_addr;
      op_f3    = mem_if.req_funct3;
      op_wdata = mem_if.req_wdata;
    end else begin
      op_rd    = rd_q;
      op_wr    = wr_q;
      op_addr  = addr_q;
      op_f3    = funct3_q;
      op_wdata = wdata_q;
    end
    misaligned = ((op_f3[1:0] == 2'b01) && op_addr[0]) ||
                 ((op_f3[1:0] == 2'b10) && (op_addr[1:0] != 2'b00));
    case (op_f3)
      3'b000, 3'b001, 3'b010: bad_funct3 = 1'b0;
      3'b100, 3'b101:         bad_funct3 = op_wr;  // unsigned forms exist only for loads
      default:                bad_funct3 = 1'b1;
    endcase
    req_err = (op_rd && op_wr) || misaligned || bad_funct3;
    a1 = op_addr + ADDR_W'(1);
    a2 = op_addr + ADDR_W'(2);
    a3 = op_addr + ADDR_W'(3);
    b0 = mem_q[op_addr];
    b1 = mem_q[a1];
    b2 = mem_q[a2];
    b3 = mem_q[a3];
    case (op_f3)
      3'b000:  load_word = {{24{b0[7]}}, b0};
      3'b001:  load_word = {{16{b1[7]}}, b1, b0};
      3'b100:  load_word = {24'd0, b0};
      3'b101:  load_word = {16'd0, b1, b0};
      default: load_word = {b3, b2, b1, b0};
    endcase
  end

  // Request FSM with registered response outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (enter_resp) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= req_err;
        rsp_rdata_q <= (op_rd && !req_err) ? DATA_W'(load_word) : '0;
      end
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            addr_q   <= mem_if.req_addr;
            funct3_q <= mem_if.req_funct3;
            wdata_q  <= mem_if.req_wdata;
            rd_q     <= mem_if.req_rd;
            wr_q     <= mem_if.req_wr;
            cnt_q    <= CntLoad;
            state_q  <= (LATENCY == 0) ? StResp : StWait;
          end
        end
        StWait: begin
          if (cnt_q == 4'd0) state_q <= StResp;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Store commit on the edge entering RESP; a reset on that edge aborts it.
  always_ff @(posedge clk) begin
    if (reset && enter_resp && op_wr && !req_err) begin
      mem_q[op_addr] <= op_wdata[7:0];
      if (op_f3[1:0] != 2'b00) mem_q[a1] <= op_wdata[15:8];
      if (op_f3[1:0] == 2'b10) begin
        mem_q[a2] <= op_wdata[23:16];
        mem_q[a3] <= op_wdata[31:24];
      end
    end
  end

  assign mem_if.req_ready = (state_q == StIdle);
  assign mem_if.rsp_valid = rsp_valid_q;
  assign mem_if.rsp_rdata = rsp_rdata_q;
  assign mem_if.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: table of loads/stores on a LATENCY=2 instance checked through
// a response scoreboard, plus hand sequences for mid-WAIT reset and LATENCY=0 back-to-back.
module tb_data_mem_responder;

  localparam int unsigned Lat = 2;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [8:0]  addr;
    logic [2:0]  f3;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t vecs[20];

  data_mem_responder_if #(.DATA_W(32), .ADDR_W(9)) bus2 ();
  data_mem_responder_if #(.DATA_W(32), .ADDR_W(9)) bus0 ();

  data_mem_responder #(.DATA_W(32), .ADDR_W(9), .LATENCY(Lat)) dut2 (
    .clk(clk), .reset(reset), .mem_if(bus2.slave)
  );
  data_mem_responder #(.DATA_W(32), .ADDR_W(9), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .mem_if(bus0.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard: every response on the LATENCY=2 instance must match the oldest expectation.
  always @(negedge clk) begin
    if (bus2.rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 32'(bus2.rsp_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_rdata", bus2.rsp_rdata, e.rdata);
        check("rsp_err", 32'(bus2.rsp_err), 32'(e.err));
        check("latency", 32'(cyc - e.acc_cyc), 32'(Lat));
      end
    end
  end

  task automatic issue(input vec_t v);
    int n;
    exp_t e;
    @(negedge clk);
    n = 0;
    while (bus2.req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_issue", 32'(bus2.req_ready), 32'd1);
    bus2.req_rd     = v.rd;
    bus2.req_wr     = v.wr;
    bus2.req_addr   = v.addr;
    bus2.req_funct3 = v.f3;
    bus2.req_wdata  = v.wdata;
    e.rdata   = v.exp_rdata;
    e.err     = v.exp_err;
    e.acc_cyc = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus2.req_rd = 1'b0;
    bus2.req_wr = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 9'h000, 3'b010, 32'h0BADF00D, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 9'h010, 3'b010, 32'hDEADBEEF, 32'h00000000, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 9'h010, 3'b010, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 9'h013, 3'b000, 32'h0,        32'hFFFFFFDE, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 9'h013, 3'b100, 32'h0,        32'h000000DE, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 9'h010, 3'b001, 32'h0,        32'hFFFFBEEF, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 9'h012, 3'b101, 32'h0,        32'h0000DEAD, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 9'h011, 3'b000, 32'hFFFFFF55, 32'h00000000, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 9'h010, 3'b010, 32'h0,        32'hDEAD55EF, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 9'h012, 3'b010, 32'h0,        32'h00000000, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 9'h001, 3'b001, 32'h0000AAAA, 32'h00000000, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 9'h000, 3'b010, 32'h0,        32'h0BADF00D, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 9'h000, 3'b010, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 9'h000, 3'b011, 32'h0,        32'h00000000, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 9'h000, 3'b011, 32'h00000000, 32'h00000000, 1'b1};
    vecs[15] = '{1'b0, 1'b1, 9'h000, 3'b100, 32'h00000000, 32'h00000000, 1'b1};
    vecs[16] = '{1'b1, 1'b0, 9'h000, 3'b010, 32'h0,        32'h0BADF00D, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 9'h1FC, 3'b010, 32'hCAFEF00D, 32'h00000000, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 9'h1FE, 3'b001, 32'h0,        32'hFFFFCAFE, 1'b0};
    vecs[19] = '{1'b1, 1'b0, 9'h003, 3'b101, 32'h0,        32'h00000000, 1'b1};

    bus2.req_rd = 1'b0; bus2.req_wr = 1'b0; bus2.req_addr = '0;
    bus2.req_funct3 = '0; bus2.req_wdata = '0;
    bus0.req_rd = 1'b0; bus0.req_wr = 1'b0; bus0.req_addr = '0;
    bus0.req_funct3 = '0; bus0.req_wdata = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_rsp_valid", 32'(bus2.rsp_valid), 32'd0);
    check("reset_rsp_rdata", bus2.rsp_rdata, 32'd0);
    check("reset_rsp_err", 32'(bus2.rsp_err), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(bus2.req_ready), 32'd1);

    for (int i = 0; i < 20; i++) begin
      issue(vecs[i]);
      drain();
      repeat (2) @(negedge clk);
      check("hold_rdata", bus2.rsp_rdata, vecs[i].exp_rdata);
      check("hold_err", 32'(bus2.rsp_err), 32'(vecs[i].exp_err));
    end

    // Store aborted by reset during WAIT must never commit or respond.
    @(negedge clk);
    bus2.req_wr = 1'b1; bus2.req_rd = 1'b0; bus2.req_addr = 9'h1FC;
    bus2.req_funct3 = 3'b010; bus2.req_wdata = 32'h12345678;
    @(posedge clk);
    #1;
    bus2.req_wr = 1'b0;
    @(negedge clk);
    check("ready_in_wait", 32'(bus2.req_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("rsp_valid_after_abort", 32'(bus2.rsp_valid), 32'd0);
    @(negedge clk);
    check("ready_after_release", 32'(bus2.req_ready), 32'd1);
    repeat (6) @(negedge clk);
    issue('{1'b1, 1'b0, 9'h1FC, 3'b010, 32'h0, 32'hCAFEF00D, 1'b0});
    drain();

    // LATENCY=0: store, then a load strobe held high is served every second cycle.
    @(negedge clk);
    bus0.req_wr = 1'b1; bus0.req_addr = 9'h004; bus0.req_funct3 = 3'b010;
    bus0.req_wdata = 32'h11223344;
    @(posedge clk);
    #1;
    bus0.req_wr = 1'b0;
    @(negedge clk);
    check("l0_store_valid", 32'(bus0.rsp_valid), 32'd1);
    check("l0_store_err", 32'(bus0.rsp_err), 32'd0);
    check("l0_store_rdata", bus0.rsp_rdata, 32'd0);
    @(negedge clk);
    bus0.req_rd = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k != 0) @(negedge clk);
      check("l0_ready", 32'(bus0.req_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
      check("l0_valid", 32'(bus0.rsp_valid), (k % 2 == 1) ? 32'd1 : 32'd0);
      if (k % 2 == 1) check("l0_rdata", bus0.rsp_rdata, 32'h11223344);
    end
    bus0.req_rd = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
